// File: rtl/accel_ramp_pkg.sv
// Shared types and arithmetic helpers for the accel_ramp velocity-profile generator.
package accel_ramp_pkg;

    localparam int VEL_W = 32;
    localparam int DUR_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } ramp_state_e;

    typedef struct packed {
        logic [VEL_W-1:0] accel;
        logic [DUR_W-1:0] duration;
        logic             set_vel;
        logic [VEL_W-1:0] velocity;
    } ramp_cmd_t;

    // Limits a 33-bit signed sum to [-vmax, +vmax].
    function automatic logic [VEL_W-1:0] sat_vel(input logic signed [VEL_W:0] sum,
                                                 input logic [VEL_W-1:0] vmax);
        logic signed [VEL_W:0] pos_lim;
        logic signed [VEL_W:0] neg_lim;
        logic [VEL_W:0]        res;
        pos_lim = $signed({1'b0, vmax});
        neg_lim = -pos_lim;
        if (sum > pos_lim) begin
            res = pos_lim;
        end else if (sum < neg_lim) begin
            res = neg_lim;
        end else begin
            res = sum;
        end
        return res[VEL_W-1:0];
    endfunction

endpackage

// File: rtl/accel_ramp_cmd_buf.sv
// One-entry holding register for motion-segment commands; ready means the entry is empty.
module ramp_cmd_buf
    import accel_ramp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEL_W-1:0] in_accel,
    input  logic [DUR_W-1:0] in_duration,
    input  logic             in_set_vel,
    input  logic [VEL_W-1:0] in_velocity,
    input  logic             pop,
    output logic             full,
    output logic [VEL_W-1:0] out_accel,
    output logic [DUR_W-1:0] out_duration,
    output logic             out_set_vel,
    output logic [VEL_W-1:0] out_velocity
);

    logic      full_q, full_d;
    ramp_cmd_t entry_q, entry_d;

    // Accept only into an empty entry, so a pop and a push never share an edge.
    always_comb begin
        full_d  = full_q;
        entry_d = entry_q;
        if (flush) begin
            full_d  = 1'b0;
            entry_d = '0;
        end else if (in_valid && !full_q) begin
            full_d  = 1'b1;
            entry_d = '{accel: in_accel, duration: in_duration,
                        set_vel: in_set_vel, velocity: in_velocity};
        end else if (pop) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else begin
            full_q  <= full_d;
            entry_q <= entry_d;
        end
    end

    assign in_ready     = !full_q;
    assign full         = full_q;
    assign out_accel    = entry_q.accel;
    assign out_duration = entry_q.duration;
    assign out_set_vel  = entry_q.set_vel;
    assign out_velocity = entry_q.velocity;

endmodule

// File: rtl/accel_ramp.sv
// Velocity-profile generator: runs queued accel segments, one velocity update per TICK_DIV clocks.
// Define ACCEL_RAMP_CLAMP_EN to saturate velocity at +/-VMAX instead of wrapping.
module accel_ramp
    import accel_ramp_pkg::*;
#(
    parameter int          TICK_DIV = 50,
    parameter logic [31:0] VMAX     = 32'h3FFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_accel,
    input  logic [31:0] cmd_duration,
    input  logic        cmd_set_vel,
    input  logic [31:0] cmd_velocity,
    input  logic        abort,
    output logic [31:0] velocity,
    output logic        busy,
    output logic        seg_done,
    output logic        underrun
);

    localparam int           TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    ramp_state_e      state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [DUR_W-1:0] remaining_q, remaining_d;
    logic [VEL_W-1:0] accel_q, accel_d;
    logic [VEL_W-1:0] velocity_q, velocity_d;
    logic             underrun_q, underrun_d;
    logic             seg_done_q, seg_done_d;

    logic             buf_full, buf_pop;
    logic [VEL_W-1:0] buf_accel, buf_velocity;
    logic [DUR_W-1:0] buf_duration;
    logic             buf_set_vel;

    logic [VEL_W:0]   vel_sum;
    logic [VEL_W-1:0] vel_next;
    logic             load;
    logic [VEL_W-1:0] load_base;
    logic [VEL_W-1:0] load_vel;

    ramp_cmd_buf u_buf (
        .clk          (clk),
        .reset        (reset),
        .flush        (abort),
        .in_valid     (cmd_valid),
        .in_ready     (cmd_ready),
        .in_accel     (cmd_accel),
        .in_duration  (cmd_duration),
        .in_set_vel   (cmd_set_vel),
        .in_velocity  (cmd_velocity),
        .pop          (buf_pop),
        .full         (buf_full),
        .out_accel    (buf_accel),
        .out_duration (buf_duration),
        .out_set_vel  (buf_set_vel),
        .out_velocity (buf_velocity)
    );

    assign vel_sum = {velocity_q[VEL_W-1], velocity_q} + {accel_q[VEL_W-1], accel_q};

`ifdef ACCEL_RAMP_CLAMP_EN
    assign vel_next = sat_vel($signed(vel_sum), VMAX);
`else
    logic unused_bits;
    assign unused_bits = vel_sum[VEL_W] ^ (^VMAX);
    assign vel_next    = vel_sum[VEL_W-1:0];
`endif

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        remaining_d = remaining_q;
        accel_d     = accel_q;
        velocity_d  = velocity_q;
        underrun_d  = underrun_q;
        seg_done_d  = 1'b0;
        buf_pop     = 1'b0;
        load        = 1'b0;
        load_base   = velocity_q;
        load_vel    = velocity_q;
        if (abort) begin
            state_d     = S_IDLE;
            tick_d      = '0;
            remaining_d = '0;
            accel_d     = '0;
            velocity_d  = '0;
            underrun_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: load = buf_full;
                S_RUN: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d      = '0;
                        velocity_d  = vel_next;
                        remaining_d = remaining_q - 1'b1;
                        if (remaining_q == DUR_W'(1)) begin
                            seg_done_d = 1'b1;
                            if (buf_full) begin
                                load      = 1'b1;
                                load_base = vel_next;
                            end else begin
                                state_d = S_IDLE;
                                if (vel_next != '0) underrun_d = 1'b1;
                            end
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
            // A freshly loaded segment overrides the ending one; zero duration finishes at once.
            if (load) begin
                buf_pop     = 1'b1;
                tick_d      = '0;
                accel_d     = buf_accel;
                remaining_d = buf_duration;
                load_vel    = buf_set_vel ? buf_velocity : load_base;
                velocity_d  = load_vel;
                if (buf_duration == '0) begin
                    seg_done_d = 1'b1;
                    state_d    = S_IDLE;
                    if (load_vel != '0) underrun_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tick_q      <= '0;
            remaining_q <= '0;
            accel_q     <= '0;
            velocity_q  <= '0;
            underrun_q  <= 1'b0;
            seg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            remaining_q <= remaining_d;
            accel_q     <= accel_d;
            velocity_q  <= velocity_d;
            underrun_q  <= underrun_d;
            seg_done_q  <= seg_done_d;
        end
    end

    assign velocity = velocity_q;
    assign busy     = (state_q == S_RUN) || buf_full;
    assign seg_done = seg_done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_accel_ramp.sv
// Directed bench for accel_ramp with TICK_DIV=4 and VMAX=1000.
module tb_accel_ramp;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_accel = '0;
    logic [31:0] cmd_duration = '0;
    logic        cmd_set_vel = 1'b0;
    logic [31:0] cmd_velocity = '0;
    logic        abort = 1'b0;
    logic [31:0] velocity;
    logic        busy;
    logic        seg_done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    accel_ramp #(.TICK_DIV(TD), .VMAX(32'd1000)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_accel    (cmd_accel),
        .cmd_duration (cmd_duration),
        .cmd_set_vel  (cmd_set_vel),
        .cmd_velocity (cmd_velocity),
        .abort        (abort),
        .velocity     (velocity),
        .busy         (busy),
        .seg_done     (seg_done),
        .underrun     (underrun)
    );

    typedef struct {
        string       name;
        logic        set_vel;
        logic [31:0] vel;
        logic [31:0] accel;
        logic [31:0] dur;
        logic [31:0] exp_vel;
        logic        exp_underrun;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_cmd(input logic sv, input logic [31:0] v, input logic [31:0] a,
                            input logic [31:0] d);
        int waited = 0;
        while (!cmd_ready && waited < 100) begin
            step();
            waited++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", {31'b0, cmd_ready}, 32'd1);
        cmd_set_vel  = sv;
        cmd_velocity = v;
        cmd_accel    = a;
        cmd_duration = d;
        cmd_valid    = 1'b1;
        step();
        cmd_valid    = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        vecs[0] = '{"ramp_up",    1'b1, 32'd100, 32'd10, 32'd3, 32'd130, 1'b1};
`ifdef ACCEL_RAMP_CLAMP_EN
        vecs[1] = '{"clamp_pos",  1'b1, 32'd990, 32'd20, 32'd1, 32'd1000, 1'b1};
        vecs[5] = '{"wrap_top",   1'b1, 32'h7FFF_FFF0, 32'h20, 32'd1, 32'd1000, 1'b1};
        vecs[6] = '{"clamp_neg",  1'b1, -32'sd990, -32'sd20, 32'd1, -32'sd1000, 1'b1};
`else
        vecs[1] = '{"clamp_pos",  1'b1, 32'd990, 32'd20, 32'd1, 32'd1010, 1'b1};
        vecs[5] = '{"wrap_top",   1'b1, 32'h7FFF_FFF0, 32'h20, 32'd1, 32'h8000_0010, 1'b1};
        vecs[6] = '{"clamp_neg",  1'b1, -32'sd990, -32'sd20, 32'd1, -32'sd1010, 1'b1};
`endif
        vecs[2] = '{"ramp_to_0",  1'b1, -32'sd50, 32'd25, 32'd2, 32'd0, 1'b0};
        vecs[3] = '{"dur_zero",   1'b1, 32'd500, 32'd7, 32'd0, 32'd500, 1'b1};
        vecs[4] = '{"no_set_vel", 1'b0, 32'd999, 32'd5, 32'd2, 32'd10, 1'b1};

        // Reset state
        steps(2);
        reset = 1'b0;
        check("rst_velocity", velocity, 32'd0);
        check("rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_seg_done", {31'b0, seg_done}, 32'd0);
        check("rst_underrun", {31'b0, underrun}, 32'd0);

        // Table: one segment each from an aborted (zero-velocity) start
        for (int i = 0; i < 7; i++) begin
            int lat;
            bit done;
            do_abort();
            send_cmd(vecs[i].set_vel, vecs[i].vel, vecs[i].accel, vecs[i].dur);
            lat = 0;
            done = 1'b0;
            for (int k = 0; k < 200 && !done; k++) begin
                step();
                lat++;
                if (seg_done) done = 1'b1;
            end
            check({vecs[i].name, "_latency"}, lat, 1 + vecs[i].dur * TD);
            check({vecs[i].name, "_velocity"}, velocity, vecs[i].exp_vel);
            check({vecs[i].name, "_underrun"}, {31'b0, underrun}, {31'b0, vecs[i].exp_underrun});
            check({vecs[i].name, "_busy"}, {31'b0, busy}, 32'd0);
            step();
            check({vecs[i].name, "_hold"}, velocity, vecs[i].exp_vel);
            check({vecs[i].name, "_pulse_end"}, {31'b0, seg_done}, 32'd0);
        end

        // Reset mid-segment at velocity 300 (underrun is set from the last table entry)
        send_cmd(1'b1, 32'd300, 32'd0, 32'd5);
        step();
        steps(3);
        check("mid_velocity", velocity, 32'd300);
        check("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_velocity", velocity, 32'd0);
        check("rst2_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst2_busy", {31'b0, busy}, 32'd0);
        check("rst2_seg_done", {31'b0, seg_done}, 32'd0);
        check("rst2_underrun", {31'b0, underrun}, 32'd0);

        // Gapless pair: 100 ->110->120->130 then 65 -> 0
        send_cmd(1'b1, 32'd100, 32'd10, 32'd3);
        step();
        check("gl_load", velocity, 32'd100);
        check("gl_ready_after_load", {31'b0, cmd_ready}, 32'd1);
        send_cmd(1'b0, 32'd0, -32'sd65, 32'd2);
        check("gl_ready_full", {31'b0, cmd_ready}, 32'd0);
        check("gl_busy", {31'b0, busy}, 32'd1);
        steps(2);
        check("gl_pre_step", velocity, 32'd100);
        step();
        check("gl_step1", velocity, 32'd110);
        steps(4);
        check("gl_step2", velocity, 32'd120);
        steps(4);
        check("gl_step3", velocity, 32'd130);
        check("gl_done1", {31'b0, seg_done}, 32'd1);
        check("gl_busy_chain", {31'b0, busy}, 32'd1);
        check("gl_ready_freed", {31'b0, cmd_ready}, 32'd1);
        step();
        check("gl_done1_end", {31'b0, seg_done}, 32'd0);
        steps(3);
        check("gl_step4", velocity, 32'd65);
        check("gl_mid_done", {31'b0, seg_done}, 32'd0);
        steps(4);
        check("gl_step5", velocity, 32'd0);
        check("gl_done2", {31'b0, seg_done}, 32'd1);
        check("gl_idle", {31'b0, busy}, 32'd0);
        check("gl_underrun", {31'b0, underrun}, 32'd0);

        // Abort in RUN with a full buffer, command offered in the abort cycle
        send_cmd(1'b1, 32'd5, 32'd0, 32'd0);
        step();
        check("ab_pre_underrun", {31'b0, underrun}, 32'd1);
        send_cmd(1'b1, 32'd100, 32'd10, 32'd3);
        step();
        send_cmd(1'b0, 32'd0, 32'd1, 32'd2);
        steps(4);
        check("ab_pre_velocity", velocity, 32'd110);
        cmd_set_vel  = 1'b1;
        cmd_velocity = 32'd77;
        cmd_accel    = 32'd1;
        cmd_duration = 32'd3;
        cmd_valid    = 1'b1;
        abort        = 1'b1;
        step();
        abort        = 1'b0;
        cmd_valid    = 1'b0;
        check("ab_velocity", velocity, 32'd0);
        check("ab_busy", {31'b0, busy}, 32'd0);
        check("ab_ready", {31'b0, cmd_ready}, 32'd1);
        check("ab_underrun", {31'b0, underrun}, 32'd0);
        steps(3);
        check("ab_no_accept", {31'b0, busy}, 32'd0);
        check("ab_vel_hold", velocity, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
